// File: rtl/seq_gen_pkg.sv
// Shared types and default constants for the sequence-generator controller.
// The top level and the bench both import this package.
package seq_gen_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_OP_W   = 5;
    localparam int unsigned DEF_CNT_W  = 8;

    localparam int unsigned DEF_OP_ADD = 0;
    localparam int unsigned DEF_REG_Z  = 0;
    localparam int unsigned DEF_REG_A  = 1;
    localparam int unsigned DEF_REG_B  = 2;
    localparam int unsigned DEF_REG_T  = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT1  = 3'd1,
        S_INIT2  = 3'd2,
        S_STEP   = 3'd3,
        S_SHIFT1 = 3'd4,
        S_SHIFT2 = 3'd5,
        S_LOOP   = 3'd6,
        S_DONE   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        MODE_ADD   = 2'b00,
        MODE_ARITH = 2'b01,
        MODE_DBL   = 2'b10,
        MODE_RSV   = 2'b11
    } mode_e;

    // The reserved encoding runs the additive recurrence.
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_ADD : mode_e'(m);
    endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Request/status handshake plus register-file/ALU control bundle of the
// sequence-generator controller.
interface seq_gen_if #(
    parameter int unsigned DATA_W = seq_gen_pkg::DEF_DATA_W,
    parameter int unsigned ADDR_W = seq_gen_pkg::DEF_ADDR_W,
    parameter int unsigned OP_W   = seq_gen_pkg::DEF_OP_W,
    parameter int unsigned CNT_W  = seq_gen_pkg::DEF_CNT_W
);
    logic              en;
    logic              start;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed_a;
    logic [DATA_W-1:0] seed_b;
    logic [CNT_W-1:0]  num_terms;
    logic              alu_carry;

    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic [ADDR_W-1:0] w_addr;
    logic              we;
    logic [OP_W-1:0]   alu_op;
    logic              use_const;
    logic [DATA_W-1:0] const_val;
    logic              busy;
    logic              done;
    logic              term_valid;
    logic [CNT_W-1:0]  term_idx;
    logic              ovf;

    // Controller side: drives the datapath and reports status.
    modport master (
        input  en, start, mode, seed_a, seed_b, num_terms, alu_carry,
        output ra_addr, rb_addr, w_addr, we, alu_op, use_const, const_val,
        output busy, done, term_valid, term_idx, ovf
    );

    // Environment side: requester plus register file/ALU.
    modport slave (
        output en, start, mode, seed_a, seed_b, num_terms, alu_carry,
        input  ra_addr, rb_addr, w_addr, we, alu_op, use_const, const_val,
        input  busy, done, term_valid, term_idx, ovf
    );

endinterface

// File: rtl/seq_gen_ctrl.sv
// Sequence-generator controller: sequences the 2R/1W register file and ALU to
// produce additive, arithmetic or doubling sequences with overflow stop.
module seq_gen_ctrl
    import seq_gen_pkg::*;
#(
    parameter int unsigned      DATA_W      = DEF_DATA_W,
    parameter int unsigned      ADDR_W      = DEF_ADDR_W,
    parameter int unsigned      OP_W        = DEF_OP_W,
    parameter int unsigned      CNT_W       = DEF_CNT_W,
    parameter logic [OP_W-1:0]  OP_ADD      = OP_W'(DEF_OP_ADD),
    parameter logic [ADDR_W-1:0] REG_Z      = ADDR_W'(DEF_REG_Z),
    parameter logic [ADDR_W-1:0] REG_A      = ADDR_W'(DEF_REG_A),
    parameter logic [ADDR_W-1:0] REG_B      = ADDR_W'(DEF_REG_B),
    parameter logic [ADDR_W-1:0] REG_T      = ADDR_W'(DEF_REG_T),
    parameter bit               STOP_ON_OVF = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_gen_if.master bus
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DATA_W-1:0] seed_a_q, seed_a_d;
    logic [DATA_W-1:0] seed_b_q, seed_b_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  term_idx_q, term_idx_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] ra_c, rb_c, wa_c;
    logic              wr_c, use_const_c, tv_c;
    logic [DATA_W-1:0] const_c;
    logic              last_term_c, carry_stop_c;

    // State and latched run configuration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_ADD;
            seed_a_q   <= '0;
            seed_b_q   <= '0;
            num_q      <= '0;
            term_idx_q <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            seed_a_q   <= seed_a_d;
            seed_b_q   <= seed_b_d;
            num_q      <= num_d;
            term_idx_q <= term_idx_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign last_term_c  = (term_idx_q == (num_q - CNT_W'(1)));
    assign carry_stop_c = STOP_ON_OVF & bus.alu_carry;

    // Next state, counters and datapath controls.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_a_d    = seed_a_q;
        seed_b_d    = seed_b_q;
        num_d       = num_q;
        term_idx_d  = term_idx_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        ra_c        = REG_Z;
        rb_c        = REG_Z;
        wa_c        = REG_Z;
        wr_c        = 1'b0;
        use_const_c = 1'b0;
        const_c     = '0;
        tv_c        = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    mode_d     = decode_mode(bus.mode);
                    seed_a_d   = bus.seed_a;
                    seed_b_d   = bus.seed_b;
                    num_d      = bus.num_terms;
                    ovf_d      = 1'b0;
                    term_idx_d = '0;
                    if (bus.num_terms == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_INIT1;
                    end
                end
            end
            S_INIT1: begin
                use_const_c = 1'b1;
                const_c     = seed_a_q;
                wa_c        = REG_A;
                wr_c        = 1'b1;
                if (bus.en) state_d = S_INIT2;
            end
            S_INIT2: begin
                use_const_c = 1'b1;
                const_c     = seed_b_q;
                wa_c        = REG_B;
                wr_c        = 1'b1;
                tv_c        = 1'b1;
                if (bus.en) begin
                    term_idx_d = term_idx_q + CNT_W'(1);
                    if (last_term_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (mode_q == MODE_ADD) begin
                        state_d = S_STEP;
                    end else begin
                        state_d = S_LOOP;
                    end
                end
            end
            S_STEP: begin
                ra_c = REG_A;
                rb_c = REG_B;
                wa_c = REG_T;
                wr_c = 1'b1;
                if (bus.en) begin
                    if (bus.alu_carry) ovf_d = 1'b1;
                    if (carry_stop_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SHIFT1;
                    end
                end
            end
            S_SHIFT1: begin
                ra_c = REG_B;
                wa_c = REG_A;
                wr_c = 1'b1;
                if (bus.en) state_d = S_SHIFT2;
            end
            S_SHIFT2: begin
                ra_c = REG_T;
                wa_c = REG_B;
                wr_c = 1'b1;
                tv_c = 1'b1;
                if (bus.en) begin
                    term_idx_d = term_idx_q + CNT_W'(1);
                    if (last_term_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_LOOP: begin
                ra_c = REG_B;
                rb_c = (mode_q == MODE_DBL) ? REG_B : REG_A;
                wa_c = REG_B;
                wr_c = 1'b1;
                // A stopping overflow still writes but does not count as a term.
                tv_c = ~carry_stop_c;
                if (bus.en) begin
                    if (bus.alu_carry) ovf_d = 1'b1;
                    if (carry_stop_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        term_idx_d = term_idx_q + CNT_W'(1);
                        if (last_term_c) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Writes are suppressed while stalled or while reset is being applied.
    assign bus.ra_addr    = ra_c;
    assign bus.rb_addr    = rb_c;
    assign bus.w_addr     = wa_c;
    assign bus.we         = wr_c & bus.en & rst_n;
    assign bus.alu_op     = OP_ADD;
    assign bus.use_const  = use_const_c;
    assign bus.const_val  = const_c;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done       = done_q;
    assign bus.term_valid = tv_c & bus.en & rst_n;
    assign bus.term_idx   = term_idx_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: doc/seq_gen_ctrl.md
Name: seq_gen_ctrl

Overview:
- Parametrised sequence-generator controller driving the 2-read/1-write register file and the 16-bit-class ALU datapath through address, write-enable, ALU-op and constant-injection controls.
- Successor to the fixed Fibonacci controller. Adds:
  - runtime mode selection: additive recurrence, arithmetic progression, doubling
  - runtime seeds and term count
  - start/busy/done handshake, step-enable stalling, term strobes
  - sticky overflow stop from the ALU carry

Parameters:
- DATA_W, 16, datapath and seed width.
- ADDR_W, 4, register-file address width.
- OP_W, 5, ALU opcode width.
- CNT_W, 8, term-count / term-index width.
- OP_ADD, 0, ALU opcode for ADD.
- REG_Z, 0, register that always reads zero; never written.
- REG_A, 1, recurrence register A.
- REG_B, 2, recurrence register B (current term).
- REG_T, 3, temporary register.
- STOP_ON_OVF, 1, 1 = end sequence on ALU carry; 0 = wrap and continue.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  step enable; a state advances only on edges where en=1
- start  in  1  start request; accepted only in IDLE or DONE, en not required
- mode  in  2  00 additive (Fibonacci-type), 01 arithmetic, 10 doubling, 11 treated as 00
- seed_a  in  DATA_W  initial REG_A (stride in arithmetic mode)
- seed_b  in  DATA_W  initial REG_B (first term)
- num_terms  in  CNT_W  number of terms to produce
- alu_carry  in  1  ALU carry-out for the current operation
- ra_addr  out  ADDR_W  read port A address
- rb_addr  out  ADDR_W  read port B address
- w_addr  out  ADDR_W  write address
- we  out  1  register-file write enable
- alu_op  out  OP_W  ALU opcode
- use_const  out  1  substitute const_val for read port B data
- const_val  out  DATA_W  injected constant (latched seed)
- busy  out  1  high from INIT1 through the last working state
- done  out  1  one-cycle pulse on entry to DONE
- term_valid  out  1  high in the cycle whose edge writes a new term into REG_B
- term_idx  out  CNT_W  0-based index of the term being written
- ovf  out  1  sticky overflow; cleared on an accepted start

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; busy=done=ovf=0; term_idx=0; latched mode/seeds/count=0. Reset mid-run aborts immediately; no further writes.
- Outputs are combinational from state. alu_op=OP_ADD always; use_const=0, we=0, all addresses=REG_Z unless listed below. we and term_valid are gated by en.
- Start accepted (IDLE/DONE, start=1): latch mode, seeds, num_terms; clear ovf and term_idx.
  - num_terms=0: go to DONE with done pulse and no writes.
  - Otherwise go to INIT1.
  - start while busy is ignored.
- INIT1: REG_A <= REG_Z + seed_a (ra=REG_Z, use_const, const_val=seed_a, w=REG_A) -> INIT2.
- INIT2: REG_B <= REG_Z + seed_b (const) with term_valid, term_idx=0.
  - num_terms=1 -> DONE.
  - Else -> STEP (mode 00) or LOOP (01/10).
- Mode 00, three states per term:
  - STEP: REG_T <= REG_A + REG_B
  - SHIFT1: REG_A <= REG_B + REG_Z
  - SHIFT2: REG_B <= REG_T + REG_Z, term_valid
- Mode 01, one state per term. LOOP: REG_B <= REG_B + REG_A, term_valid.
- Mode 10, one state per term. LOOP: REG_B <= REG_B + REG_B, term_valid.
- term_idx increments after each term write. After the write of index num_terms-1, go to DONE.
- Overflow: alu_carry sampled only at edges of STEP and LOOP with en=1.
  - STOP_ON_OVF=1: the write at that edge occurs, ovf<=1, state -> DONE, term_valid suppressed in that cycle, term not counted.
  - STOP_ON_OVF=0: ovf still sets sticky; sequence continues with wrapped values.
- en=0: state, counters and outputs hold; we=term_valid=0.
- DONE: outputs idle, busy=0. Stays until the next start.
- Widths: term_idx wraps never; num_terms bounds it.

Decomposition:
- Shared package seq_gen_pkg:
  - state enumeration (IDLE, INIT1, INIT2, STEP, SHIFT1, SHIFT2, LOOP, DONE)
  - mode encodings
  - OP_ADD and default register indices, reused by the top-level and bench
- Single module; no sub-module. The term counter is inline.

Test Plan:
1. Mode 00, seeds 0/1, num_terms=6, en=1 -> REG_B terms 1,1,2,3,5,8 with term_idx 0..5. DONE entered 17 cycles after INIT1. done pulses once. ovf=0.
2. Mode 01, seed_a=3, seed_b=10, num_terms=4 -> terms 10,13,16,19 on consecutive LOOP cycles; done after the 4th.
3. Mode 10, seed_b=1, num_terms=20, DATA_W=16, STOP_ON_OVF=1 -> terms 1..32768 (16 terms, last term_idx=15). Carry on the next LOOP gives ovf=1, DONE, no 17th term_valid.
4. en toggling 1,0,0,1 during mode 00 run -> no state advance or we while en=0. Same term sequence as scenario 1.
5. num_terms=0 -> done pulse next cycle, we never asserted. A start during busy is ignored (latched seeds unchanged).
6. rst_n=0 during SHIFT1 -> next cycle IDLE, busy=0, we=0, ovf=0. A fresh start reruns scenario 1 correctly.
